// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : Architectural register file with rename tracking. Each register
//            holds a value, a "referenced" bit and the ROB tag of the pending
//            producer. Reads are combinational with commit bypass.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int ROB_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      read_en_1,
    input  logic [4:0]                read_addr_1,
    output logic                      read_is_ref_1,
    output logic [31:0]               read_data_1,
    input  logic                      read_en_2,
    input  logic [4:0]                read_addr_2,
    output logic                      read_is_ref_2,
    output logic [31:0]               read_data_2,
    input  logic                      write_en,
    input  logic [4:0]                write_addr,
    input  logic [ROB_ADDR_WIDTH-1:0] write_rob_id,
    input  logic                      commit_en,
    input  logic [4:0]                commit_addr,
    input  logic [ROB_ADDR_WIDTH-1:0] commit_rob_id,
    input  logic [31:0]               commit_data,
    output logic [5:0]                ref_count
);

    logic [31:0]               values [32];
    logic [31:0]               ref_bits;
    logic [ROB_ADDR_WIDTH-1:0] tags   [32];

    // A rename is only honoured for a real register and when not flushing.
    logic rename_ok;
    // Commit value write happens for any non-zero destination.
    logic commit_wr;
    // Commit matches the youngest pending producer of its register.
    logic commit_hit;
    // The matching commit actually clears the ref bit (no same-cycle rename).
    logic commit_clears;
    // A rename that turns an unreferenced register into a referenced one.
    logic count_inc;

    assign rename_ok     = write_en && (write_addr != 5'd0) && !flush;
    assign commit_wr     = commit_en && (commit_addr != 5'd0);
    assign commit_hit    = commit_wr && ref_bits[commit_addr]
                           && (tags[commit_addr] == commit_rob_id);
    assign commit_clears = commit_hit && !(rename_ok && (write_addr == commit_addr));
    assign count_inc     = rename_ok && !ref_bits[write_addr];

    // Storage update: commit writes the value, rename takes precedence on ref/tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                values[i] <= '0;
                tags[i]   <= '0;
            end
            ref_bits <= '0;
        end else begin
            if (commit_wr) begin
                values[commit_addr] <= commit_data;
            end
            if (flush) begin
                ref_bits <= '0;
            end else begin
                if (commit_clears) begin
                    ref_bits[commit_addr] <= 1'b0;
                end
                if (rename_ok) begin
                    ref_bits[write_addr] <= 1'b1;
                    tags[write_addr]     <= write_rob_id;
                end
            end
        end
    end

    // Running count of referenced registers, kept in step with ref_bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_count <= '0;
        end else if (flush) begin
            ref_count <= '0;
        end else if (count_inc && !commit_clears) begin
            if (ref_count < 6'd31) begin
                ref_count <= ref_count + 6'd1;
            end
        end else if (commit_clears && !count_inc) begin
            if (ref_count != 6'd0) begin
                ref_count <= ref_count - 6'd1;
            end
        end
    end

    // Two identical combinational read ports; same-cycle renames are invisible.
    for (genvar p = 0; p < 2; p++) begin : g_read_port
        logic        en;
        logic [4:0]  addr;
        logic        is_ref;
        logic [31:0] data;

        assign en   = (p == 0) ? read_en_1   : read_en_2;
        assign addr = (p == 0) ? read_addr_1 : read_addr_2;

        // Select stored value, bypassed commit data or zero-extended tag.
        always_comb begin
            is_ref = 1'b0;
            data   = 32'd0;
            if (rst && en && (addr != 5'd0)) begin
                if (!ref_bits[addr]) begin
                    data = values[addr];
                end else if (commit_en && (commit_addr == addr)
                             && (tags[addr] == commit_rob_id)) begin
                    data = commit_data;
                end else begin
                    is_ref = 1'b1;
                    data   = 32'(tags[addr]);
                end
            end
        end
    end

    assign read_is_ref_1 = g_read_port[0].is_ref;
    assign read_data_1   = g_read_port[0].data;
    assign read_is_ref_2 = g_read_port[1].is_ref;
    assign read_data_2   = g_read_port[1].data;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Directed self-checking bench for reg_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        read_en_1, read_en_2;
    logic [4:0]  read_addr_1, read_addr_2;
    logic        read_is_ref_1, read_is_ref_2;
    logic [31:0] read_data_1, read_data_2;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [3:0]  write_rob_id;
    logic        commit_en;
    logic [4:0]  commit_addr;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_data;
    logic [5:0]  ref_count;

    int checks = 0;
    int fails  = 0;

    reg_file #(.ROB_ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .read_en_1(read_en_1), .read_addr_1(read_addr_1),
        .read_is_ref_1(read_is_ref_1), .read_data_1(read_data_1),
        .read_en_2(read_en_2), .read_addr_2(read_addr_2),
        .read_is_ref_2(read_is_ref_2), .read_data_2(read_data_2),
        .write_en(write_en), .write_addr(write_addr), .write_rob_id(write_rob_id),
        .commit_en(commit_en), .commit_addr(commit_addr),
        .commit_rob_id(commit_rob_id), .commit_data(commit_data),
        .ref_count(ref_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear all request inputs.
    task automatic idle();
        flush = 0; write_en = 0; write_addr = 0; write_rob_id = 0;
        commit_en = 0; commit_addr = 0; commit_rob_id = 0; commit_data = 0;
    endtask

    // Set up both read ports.
    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_en_1 = 1; read_addr_1 = a1; read_en_2 = 1; read_addr_2 = a2;
    endtask

    // Advance one clock edge, leaving inputs cleared 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] a, input logic [3:0] t);
        write_en = 1; write_addr = a; write_rob_id = t;
    endtask

    task automatic commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
        commit_en = 1; commit_addr = a; commit_rob_id = t; commit_data = d;
    endtask

    task automatic test_reset();
        rst = 0; idle(); rd(5'd5, 5'd0);
        #3;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b0, 32'd0, 6'd0}) begin
            fails++;
            $display("FAIL reset_state: is_ref=%0b data=%h cnt=%0d, want 0/0/0",
                     read_is_ref_1, read_data_1, ref_count);
        end
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #1;
    endtask

    // Rename then commit with matching tag, including same-cycle bypass.
    task automatic test_basic();
        rename(5'd5, 4'd3); step();
        rd(5'd5, 5'd5); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b1, 32'h3, 6'd1}) begin
            fails++;
            $display("FAIL basic_ref: is_ref=%0b data=%h cnt=%0d, want 1/00000003/1",
                     read_is_ref_1, read_data_1, ref_count);
        end
        commit(5'd5, 4'd3, 32'hDEADBEEF); #1;
        checks++;
        if ({read_is_ref_1, read_data_1} !== {1'b0, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL basic_bypass: is_ref=%0b data=%h, want 0/deadbeef",
                     read_is_ref_1, read_data_1);
        end
        step(); #1;
        checks++;
        if ({read_is_ref_2, read_data_2, ref_count} !== {1'b0, 32'hDEADBEEF, 6'd0}) begin
            fails++;
            $display("FAIL basic_after_commit: is_ref=%0b data=%h cnt=%0d, want 0/deadbeef/0",
                     read_is_ref_2, read_data_2, ref_count);
        end
    endtask

    // Stale commit must not clear a register renamed again since.
    task automatic test_younger_rename();
        rename(5'd7, 4'd2); step();
        rename(5'd7, 4'd9); step();
        commit(5'd7, 4'd2, 32'h11); step();
        rd(5'd7, 5'd7); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b1, 32'h9, 6'd1}) begin
            fails++;
            $display("FAIL stale_commit: is_ref=%0b data=%h cnt=%0d, want 1/00000009/1",
                     read_is_ref_1, read_data_1, ref_count);
        end
        commit(5'd7, 4'd9, 32'h22); step(); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b0, 32'h22, 6'd0}) begin
            fails++;
            $display("FAIL young_commit: is_ref=%0b data=%h cnt=%0d, want 0/00000022/0",
                     read_is_ref_1, read_data_1, ref_count);
        end
    endtask

    // Same-cycle rename is invisible to reads; visible next cycle.
    task automatic test_same_cycle_rename();
        commit(5'd4, 4'd0, 32'h55); step();
        rename(5'd4, 4'd6); rd(5'd4, 5'd0); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, read_is_ref_2, read_data_2} !==
            {1'b0, 32'h55, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL same_cycle_rename: is_ref=%0b data=%h r0=%0b/%h, want 0/00000055 0/0",
                     read_is_ref_1, read_data_1, read_is_ref_2, read_data_2);
        end
        step(); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b1, 32'h6, 6'd1}) begin
            fails++;
            $display("FAIL after_rename: is_ref=%0b data=%h cnt=%0d, want 1/00000006/1",
                     read_is_ref_1, read_data_1, ref_count);
        end
    endtask

    // Rename and commit colliding on one register; also +1/-1 in one edge.
    task automatic test_rename_commit_collide();
        rename(5'd12, 4'd1); step();   // count 2 (r4, r12)
        rename(5'd12, 4'd7); commit(5'd12, 4'd1, 32'hAB); step();
        rd(5'd12, 5'd12); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b1, 32'h7, 6'd2}) begin
            fails++;
            $display("FAIL rename_wins: is_ref=%0b data=%h cnt=%0d, want 1/00000007/2",
                     read_is_ref_1, read_data_1, ref_count);
        end
        rename(5'd13, 4'd2); commit(5'd12, 4'd7, 32'hCD); step(); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b0, 32'hCD, 6'd2}) begin
            fails++;
            $display("FAIL inc_dec_same_edge: is_ref=%0b data=%h cnt=%0d, want 0/000000cd/2",
                     read_is_ref_1, read_data_1, ref_count);
        end
        // Mismatched tag: value written, register stays referenced.
        commit(5'd13, 4'd5, 32'h99); step();
        rd(5'd13, 5'd13); read_en_2 = 0; #1;
        checks++;
        if ({read_is_ref_1, read_data_1, read_is_ref_2, read_data_2, ref_count} !==
            {1'b1, 32'h2, 1'b0, 32'h0, 6'd2}) begin
            fails++;
            $display("FAIL tag_mismatch_or_disabled: p1=%0b/%h p2=%0b/%h cnt=%0d, want 1/2 0/0 2",
                     read_is_ref_1, read_data_1, read_is_ref_2, read_data_2, ref_count);
        end
        commit(5'd13, 4'd2, 32'h13); step(); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b0, 32'h13, 6'd1}) begin
            fails++;
            $display("FAIL match_after_mismatch: is_ref=%0b data=%h cnt=%0d, want 0/00000013/1",
                     read_is_ref_1, read_data_1, ref_count);
        end
    endtask

    // Flush drops all refs and same-cycle rename; commit value still lands.
    task automatic test_flush();
        rename(5'd1, 4'd1); step();
        rename(5'd2, 4'd2); step();
        rename(5'd3, 4'd3); step(); #1;
        checks++;
        if (ref_count !== 6'd4) begin
            fails++;
            $display("FAIL pre_flush_count: cnt=%0d, want 4", ref_count);
        end
        flush = 1; rename(5'd8, 4'd5); commit(5'd9, 4'd0, 32'h77); step();
        rd(5'd8, 5'd9); #1;
        checks++;
        if ({ref_count, read_is_ref_1, read_data_1, read_is_ref_2, read_data_2} !==
            {6'd0, 1'b0, 32'h0, 1'b0, 32'h77}) begin
            fails++;
            $display("FAIL flush: cnt=%0d r8=%0b/%h r9=%0b/%h, want 0 0/0 0/00000077",
                     ref_count, read_is_ref_1, read_data_1, read_is_ref_2, read_data_2);
        end
        rd(5'd1, 5'd4); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, read_is_ref_2, read_data_2} !==
            {1'b0, 32'h0, 1'b0, 32'h55}) begin
            fails++;
            $display("FAIL flush_clears_refs: r1=%0b/%h r4=%0b/%h, want 0/0 0/00000055",
                     read_is_ref_1, read_data_1, read_is_ref_2, read_data_2);
        end
    endtask

    // Register zero is inert.
    task automatic test_r0();
        rename(5'd14, 4'd3); step();   // count 1
        rename(5'd0, 4'd5); commit(5'd0, 4'd5, 32'hFFFF); rd(5'd0, 5'd0); #1;
        checks++;
        if ({read_is_ref_1, read_data_1} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL r0_bypass: is_ref=%0b data=%h, want 0/0", read_is_ref_1, read_data_1);
        end
        step(); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, ref_count} !== {1'b0, 32'h0, 6'd1}) begin
            fails++;
            $display("FAIL r0_write: is_ref=%0b data=%h cnt=%0d, want 0/0/1",
                     read_is_ref_1, read_data_1, ref_count);
        end
        flush = 1; step();
    endtask

    // Count tops out at 31 when every real register is referenced.
    task automatic test_saturate();
        for (int i = 1; i < 32; i++) begin
            rename(5'(i), 4'(i)); step();
        end
        rename(5'd1, 4'd2); step(); #1;
        checks++;
        if (ref_count !== 6'd31) begin
            fails++;
            $display("FAIL saturate: cnt=%0d, want 31", ref_count);
        end
        flush = 1; step(); #1;
        checks++;
        if (ref_count !== 6'd0) begin
            fails++;
            $display("FAIL flush_from_full: cnt=%0d, want 0", ref_count);
        end
    endtask

    // Asynchronous reset in mid-cycle, then normal operation afterwards.
    task automatic test_reset_mid();
        rename(5'd10, 4'd15); step(); #1;
        checks++;
        if ({read_is_ref_1, ref_count} !== {1'b0, 6'd1}) begin
            fails++;
            $display("FAIL pre_reset: cnt=%0d, want 1", ref_count);
        end
        rd(5'd10, 5'd9); rename(5'd11, 4'd1); commit(5'd10, 4'd15, 32'hAA);
        #1 rst = 0;
        #1;
        checks++;
        if ({read_is_ref_1, read_data_1, read_is_ref_2, read_data_2, ref_count} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 6'd0}) begin
            fails++;
            $display("FAIL reset_mid: r10=%0b/%h r9=%0b/%h cnt=%0d, want all 0",
                     read_is_ref_1, read_data_1, read_is_ref_2, read_data_2, ref_count);
        end
        @(posedge clk);
        #3 rst = 1;
        idle();
        @(posedge clk); #1;
        rd(5'd10, 5'd11); rename(5'd11, 4'd4); #1;
        checks++;
        if ({read_is_ref_1, read_data_1, read_is_ref_2, read_data_2, ref_count} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 6'd0}) begin
            fails++;
            $display("FAIL after_reset: r10=%0b/%h r11=%0b/%h cnt=%0d, want all 0",
                     read_is_ref_1, read_data_1, read_is_ref_2, read_data_2, ref_count);
        end
        step(); #1;
        checks++;
        if ({read_is_ref_2, read_data_2, ref_count} !== {1'b1, 32'h4, 6'd1}) begin
            fails++;
            $display("FAIL first_edge_after_reset: is_ref=%0b data=%h cnt=%0d, want 1/00000004/1",
                     read_is_ref_2, read_data_2, ref_count);
        end
    endtask

    initial begin
        read_en_1 = 0; read_en_2 = 0; read_addr_1 = 0; read_addr_2 = 0;
        test_reset();
        test_basic();
        test_younger_rename();
        test_same_cycle_rename();
        test_rename_commit_collide();
        test_flush();
        test_r0();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: ROB_ADDR_WIDTH, default 4, width of ROB entry tag stored per renamed register.
REQ-002 The block SHALL provide exactly these ports:
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  asynchronous, active-low reset
  flush  in  1  pipeline flush (mispredict or exception); discard all pending references
  read_en_1 / read_en_2  in  1  read port enable
  read_addr_1 / read_addr_2  in  5  read register index
  read_is_ref_1 / read_is_ref_2  out  1  data field holds a ROB tag, not a value
  read_data_1 / read_data_2  out  32  register value or zero-extended ROB tag
  write_en  in  1  rename request from decode
  write_addr  in  5  destination register being renamed
  write_rob_id  in  ROB_ADDR_WIDTH  ROB entry that will produce the value
  commit_en  in  1  ROB commit strobe
  commit_addr  in  5  committed destination register
  commit_rob_id  in  ROB_ADDR_WIDTH  committing ROB entry
  commit_data  in  32  committed value
  ref_count  out  6  number of registers currently marked as referenced

Function
REQ-003 Storage SHALL be 32 x 32-bit values, 32 ref bits and 32 x ROB_ADDR_WIDTH tags.
REQ-004 Reads SHALL be combinational; a disabled port or address 0 SHALL return is_ref=0, data=0.
REQ-005 For an enabled read of an unreferenced register, the port SHALL return is_ref=0 and the stored value.
REQ-006 For an enabled read of a referenced register, the port SHALL return is_ref=1 and the tag zero-extended to 32 bits.
REQ-007 Commit bypass: if commit_en, commit_addr equals the read address (non-zero), that register is referenced, and its tag equals commit_rob_id, the port SHALL return is_ref=0 and commit_data in the same cycle.
REQ-008 Rename requests in the current cycle SHALL NOT affect read outputs in that cycle; a source equal to the destination reads the pre-rename state.
REQ-009 On commit_en with commit_addr != 0, the value SHALL be written at the next edge regardless of tag match.
REQ-010 Commit SHALL clear the ref bit only when the register is referenced and its tag equals commit_rob_id; otherwise the ref bit and tag are unchanged, because a younger rename is pending.
REQ-011 On write_en with write_addr != 0 and flush=0, the ref bit SHALL be set and the tag loaded with write_rob_id at the next edge.
REQ-012 Rename and commit to the same register in the same cycle: the value SHALL be written, and the ref bit and tag SHALL take the rename (rename wins).
REQ-013 On flush, all ref bits SHALL clear at the next edge; a same-cycle rename SHALL be dropped; a same-cycle commit value write SHALL still occur.
REQ-014 Register 0 SHALL never be written, never be referenced, and always read as 0.
REQ-015 ref_count SHALL be a registered count equal to the number of set ref bits after each edge.
  - Per edge, +1 for a rename of an unreferenced register.
  - Per edge, -1 for a tag-matching commit not overridden by a rename.
  - Flush SHALL set it to 0.
  - It SHALL never exceed 31.

Reset
REQ-016 While rst=0, the block SHALL clear all values, ref bits, tags and ref_count to 0 asynchronously; reset asserted mid-operation SHALL discard pending renames and commits.
REQ-017 Read outputs SHALL be 0 with is_ref=0 during reset.
REQ-018 The first edge after rst deasserts SHALL process inputs normally.

Verification
REQ-019 Rename r5 with tag 3, then read r5 -> is_ref=1, data=0x00000003, ref_count=1; commit r5/tag 3/0xDEADBEEF -> same-cycle read returns 0xDEADBEEF, is_ref=0; next cycle ref_count=0.
REQ-020 Rename r7 with tag 2, then rename r7 with tag 9, then commit r7/tag 2/0x11 -> read r7 gives is_ref=1, data=9; commit r7/tag 9/0x22 -> read 0x22, is_ref=0.
REQ-021 Same cycle: rename r4 with tag 6, and read r4 with a stored value of 0x55 -> read returns 0x55, is_ref=0; next cycle read returns is_ref=1, data=6.
REQ-022 Rename r1, r2, r3; then flush with a simultaneous rename of r8 and commit r9/0x77 -> ref_count=0, r8 is unreferenced, r9=0x77.
REQ-023 Rename and commit of r0, then read r0 -> is_ref=0, data=0, ref_count unchanged.
REQ-024 Rename r10, pulse rst low mid-cycle -> outputs are immediately 0 and ref_count=0; after release, r10 reads 0 with is_ref=0.
